uart_rx_unit: RTL
=================

UART_RX_UNIT -- requirements
Module: uart_rx_unit

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000: system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600: serial bit rate.
REQ-003 Parameter OVERSAMPLE, default 16: ticks per bit period.
REQ-004 Port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port i_rx  input  1  asynchronous serial line, idle high.
REQ-007 Port o_rx_data  output  8  last correctly framed byte.
REQ-008 Port os_rx_done  output  1  one-cycle pulse: o_rx_data is a new valid byte.
REQ-009 Port os_frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 Port os_busy  output  1  high in every state except IDLE.

Function
REQ-011 i_rx passes through a 2-flop synchronizer; all FSM decisions use the synchronized value (2-cycle input latency).
REQ-012 Tick divisor DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer floor, minimum 1.
REQ-013 Tick counter free-runs 0..DIV-1; tick asserts for one cycle when counter == DIV-1, then wraps to 0.
REQ-014 States: IDLE, START, DATA, STOP, BREAK_WAIT.
REQ-015 IDLE: synchronized line low -> START, sample-tick counter cleared.
REQ-016 START: at tick count OVERSAMPLE/2-1, line low -> DATA with tick counter cleared; line high -> IDLE (glitch rejected, no pulse).
REQ-017 DATA: every OVERSAMPLE ticks, sample line into the shift register LSB first; after the 8th bit -> STOP.
REQ-018 STOP: after OVERSAMPLE ticks, sample line; high -> load o_rx_data, pulse os_rx_done, go IDLE; low -> pulse os_frame_err, go BREAK_WAIT, o_rx_data unchanged.
REQ-019 BREAK_WAIT: remain until synchronized line is high, then go IDLE; a held-low line never starts a new frame.
REQ-020 os_rx_done and os_frame_err are registered, high exactly one clk in the cycle after the stop-sample tick, and never high together.
REQ-021 o_rx_data holds its value between os_rx_done pulses, including across framing errors.
REQ-022 A start edge arriving in the same cycle as the stop-bit sample is not lost: FSM enters IDLE, then START on the following cycle.

Reset
REQ-023 Reset returns the FSM to IDLE and clears the tick counter, sample counter, bit counter and shift register.
REQ-024 Reset value of all outputs: o_rx_data = 8'h00, os_rx_done = 0, os_frame_err = 0, os_busy = 0.
REQ-025 Synchronizer flops reset to 1 (line idle).
REQ-026 Reset asserted mid-frame discards the partial byte with no pulse; reception restarts at the next falling edge after release.

Structure
REQ-027 State encodings and the default OVERSAMPLE value are held in a shared header (uart_defs.vh), also used by the transmitter.
REQ-028 The tick generator is a separate sub-module, baud_tick_gen (parameter DIV; ports clk, rst, os_tick).
REQ-029 The block feeds the debugger top unit directly: o_rx_data connects to i_rx_data, os_rx_done connects to is_rx_done.

Verification
REQ-030 Bench parameters CLK_FREQ=1_600_000, BAUD=10_000 (DIV=10, bit = 160 clk).
REQ-031 Send 0x01 framed correctly -> one os_rx_done pulse, o_rx_data=0x01, os_frame_err never high.
REQ-032 Back-to-back 0xA5 then 0x3C with no idle gap -> two os_rx_done pulses about 1600 clk apart, data 0xA5 then 0x3C.
REQ-033 Low glitch of 40 clk on an idle line -> FSM returns to IDLE, no pulses, o_rx_data unchanged.
REQ-034 Send 0x55 with stop bit low, then hold line low 3200 clk -> one os_frame_err pulse, no os_rx_done, os_busy high until line rises, o_rx_data keeps previous value.
REQ-035 Assert rst for 1 clk during bit 4 of 0xFF, then send 0x02 -> no pulse for the aborted byte, os_rx_done with o_rx_data=0x02.
REQ-036 Reset with line idle -> all outputs equal the REQ-024 values on the first clock edge after reset.

Source files
------------

// File: rtl/uart_rx_unit_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// default oversampling ratio and the baud tick divisor calculation.
package uart_rx_unit_pkg;

    localparam int DEFAULT_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_STOP       = 3'd3,
        ST_BREAK_WAIT = 3'd4
    } rx_state_t;

    // Clocks per oversample tick, floored, never below one.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        int div;
        div = clk_freq / (baud * oversample);
        return (div < 1) ? 1 : div;
    endfunction

endpackage

// File: rtl/uart_rx_unit_baud_tick_gen.sv
// Free-running divider producing a one-clock tick every DIV clocks,
// used as the oversampling time base for the receiver.
module baud_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic os_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign os_tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_unit.sv
// 8N1 UART receiver: synchronizes the serial line, oversamples it and
// reports each received byte or framing error with a one-clock pulse.
module uart_rx_unit
    import uart_rx_unit_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic [7:0] o_rx_data,
    output logic       os_rx_done,
    output logic       os_frame_err,
    output logic       os_busy
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int SW  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [SW-1:0] LAST_SAMPLE = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] MID_SAMPLE  = SW'(OVERSAMPLE / 2 - 1);

    logic            rx_meta;
    logic            rx_sync;
    logic            tick;
    rx_state_t       state;
    logic [SW-1:0]   sample_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;

    baud_tick_gen #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .os_tick (tick)
    );

    // Synchronizer resets to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            sample_cnt   <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            o_rx_data    <= '0;
            os_rx_done   <= 1'b0;
            os_frame_err <= 1'b0;
            os_busy      <= 1'b0;
        end else begin
            os_rx_done   <= 1'b0;
            os_frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_sync) begin
                        state      <= ST_START;
                        sample_cnt <= '0;
                        os_busy    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (sample_cnt == MID_SAMPLE) begin
                            sample_cnt <= '0;
                            if (!rx_sync) begin
                                state   <= ST_DATA;
                                bit_cnt <= '0;
                            end else begin
                                state   <= ST_IDLE;
                                os_busy <= 1'b0;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (sample_cnt == LAST_SAMPLE) begin
                            sample_cnt <= '0;
                            shift      <= {rx_sync, shift[7:1]};
                            bit_cnt    <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7) begin
                                state <= ST_STOP;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (sample_cnt == LAST_SAMPLE) begin
                            sample_cnt <= '0;
                            if (rx_sync) begin
                                o_rx_data  <= shift;
                                os_rx_done <= 1'b1;
                                state      <= ST_IDLE;
                                os_busy    <= 1'b0;
                            end else begin
                                os_frame_err <= 1'b1;
                                state        <= ST_BREAK_WAIT;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
                ST_BREAK_WAIT: begin
                    // A line held low after a bad stop bit is a break, not a new start.
                    if (rx_sync) begin
                        state   <= ST_IDLE;
                        os_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    os_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
